// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned INSTR_W         = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;
  localparam int unsigned PC_STEP_DEFAULT = 4;

  // One fetched instruction together with the byte PC it came from.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } fetch_entry_t;

  // IDLE: no word returning this cycle; WAIT: memory word arrives this cycle.
  typedef enum logic {
    StIdle,
    StWait
  } fetch_state_e;

  // Byte PC to memory word address.
  function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] pc);
    return {2'b00, pc[XLEN-1:2]};
  endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Small circular FIFO of fetch entries, absorbing decode back-pressure.
module fetch_skid_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output logic [CntW-1:0] count,
  output fetch_entry_t head
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  fetch_entry_t   mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q;
  logic [PtrW-1:0] wr_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push;
  logic            do_pop;

  // Guard against misuse: never pop empty, push into full only alongside a pop.
  always_comb begin
    do_pop  = pop && (count_q != '0);
    do_push = push && ((count_q != CntW'(DEPTH)) || do_pop);
    count   = count_q;
    head    = mem_q[rd_ptr_q];
  end

  // Pointer, count and storage update; flush drops everything buffered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '{instr: NOP_INSTR, pc: '0};
      end
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: PC, memory request tracking and credit-based issue
// into a skid FIFO feeding decode.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned PC_STEP    = PC_STEP_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  fetch_state_e    state_q;
  logic [31:0]     pc_q;
  logic [31:0]     req_pc_q;
  logic            req_q;
  logic [CntW-1:0] count;
  logic [CntW:0]   inflight;
  logic            pop;
  logic            push;
  logic            issue;
  fetch_entry_t    push_data;
  fetch_entry_t    head;
  logic            unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Credit check: buffered + returning - leaving must leave room for one more word.
  always_comb begin
    req_q     = (state_q == StWait);
    out_valid = (count != '0);
    pop       = out_valid && out_ready;
    inflight  = {1'b0, count} + (CntW + 1)'(req_q) - (CntW + 1)'(pop);
    issue     = en && !redirect_valid && (inflight < (CntW + 1)'(FIFO_DEPTH));
    push      = req_q && !redirect_valid;
    push_data = '{instr: imem_instr, pc: req_pc_q};
    imem_addr = word_addr(pc_q);
    out_instr = head.instr;
    out_pc    = head.pc;
  end

  // Request FSM and PC; redirect overrides any issue in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else if (redirect_valid) begin
      state_q <= StIdle;
      pc_q    <= {redirect_pc[31:2], 2'b00};
    end else if (issue) begin
      state_q  <= StWait;
      req_pc_q <= pc_q;
      pc_q     <= pc_q + 32'(PC_STEP);
    end else begin
      state_q <= StIdle;
    end
  end

  // A redirect flushes the FIFO, which also voids any pop in that cycle.
  fetch_skid_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a registered memory model.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        reset, en, redirect_valid, out_ready;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_instr, out_instr, out_pc;
  logic        out_valid;

  logic        reset2, en2, ready2;
  logic [31:0] imem_addr2, imem_instr2, out_instr2, out_pc2;
  logic        out_valid2;

  int n_checks = 0;
  int n_errors = 0;

  instruction_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .en             (en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  instruction_fetch_unit #(
    .RESET_PC (32'hFFFF_FFF8)
  ) dut_wrap (
    .clk            (clk),
    .reset          (reset2),
    .en             (en2),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .imem_addr      (imem_addr2),
    .imem_instr     (imem_instr2),
    .out_valid      (out_valid2),
    .out_ready      (ready2),
    .out_instr      (out_instr2),
    .out_pc         (out_pc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory: word i holds A000_0000 | i.
  always @(posedge clk) begin
    imem_instr  <= 32'hA000_0000 | imem_addr;
    imem_instr2 <= 32'hA000_0000 | imem_addr2;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [31:0] pc, input logic [31:0] instr);
    check_eq({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
    check_eq({tag, ".pc"}, out_pc, pc);
    check_eq({tag, ".instr"}, out_instr, instr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; en = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    reset2 = 1'b1; en2 = 1'b0; ready2 = 1'b0;
    repeat (2) tick();
    check_eq("rst.addr", imem_addr, 32'h0);
    check_eq("rst.valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst.instr", out_instr, 32'h0);
    check_eq("rst.pc", out_pc, 32'h0);

    // Streaming start-up.
    reset = 1'b0; en = 1'b1; out_ready = 1'b1;
    tick();
    check_eq("e1.addr", imem_addr, 32'h1);
    check_eq("e1.valid", {31'b0, out_valid}, 32'd0);
    tick();
    check_eq("e2.addr", imem_addr, 32'h2);
    check_out("e2", 32'h0, 32'hA000_0000);
    tick();
    check_eq("e3.addr", imem_addr, 32'h3);
    check_out("e3", 32'h4, 32'hA000_0001);

    // Back-pressure: head and address hold.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out("stall", 32'h4, 32'hA000_0001);
      check_eq("stall.addr", imem_addr, 32'h3);
    end
    out_ready = 1'b1;
    tick();
    check_out("rel0", 32'h8, 32'hA000_0002);
    tick();
    check_out("rel1", 32'hC, 32'hA000_0003);
    tick();
    check_out("rel2", 32'h10, 32'hA000_0004);

    // Fill the FIFO, then redirect.
    out_ready = 1'b0;
    tick();
    check_out("fill", 32'h10, 32'hA000_0004);
    check_eq("fill.addr", imem_addr, 32'h6);
    redirect_valid = 1'b1; redirect_pc = 32'h2B;
    tick();
    check_eq("redir.valid", {31'b0, out_valid}, 32'd0);
    check_eq("redir.addr", imem_addr, 32'hA);
    redirect_valid = 1'b0; out_ready = 1'b1;
    tick();
    check_eq("redir1.valid", {31'b0, out_valid}, 32'd0);
    check_eq("redir1.addr", imem_addr, 32'hB);
    tick();
    check_out("redir2", 32'h28, 32'hA000_000A);
    tick();
    check_out("redir3", 32'h2C, 32'hA000_000B);

    // Enable toggle: in-flight word still arrives, PCs stay contiguous.
    en = 1'b0;
    tick();
    check_out("en0", 32'h30, 32'hA000_000C);
    check_eq("en0.addr", imem_addr, 32'hD);
    tick();
    check_eq("en1.valid", {31'b0, out_valid}, 32'd0);
    check_eq("en1.addr", imem_addr, 32'hD);
    en = 1'b1;
    tick();
    check_eq("en2.valid", {31'b0, out_valid}, 32'd0);
    check_eq("en2.addr", imem_addr, 32'hE);
    tick();
    check_out("en3", 32'h34, 32'hA000_000D);

    // Asynchronous reset between edges.
    #3 reset = 1'b1;
    #1;
    check_eq("arst.valid", {31'b0, out_valid}, 32'd0);
    check_eq("arst.addr", imem_addr, 32'h0);
    check_eq("arst.pc", out_pc, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    check_eq("rs1.addr", imem_addr, 32'h1);
    check_eq("rs1.valid", {31'b0, out_valid}, 32'd0);
    tick();
    check_out("rs2", 32'h0, 32'hA000_0000);
    tick();
    check_out("rs3", 32'h4, 32'hA000_0001);

    // PC wrap from a high reset vector.
    reset2 = 1'b0; en2 = 1'b1; ready2 = 1'b1;
    tick();
    check_eq("wrap1.addr", imem_addr2, 32'h3FFF_FFFF);
    check_eq("wrap1.valid", {31'b0, out_valid2}, 32'd0);
    tick();
    check_eq("wrap2.addr", imem_addr2, 32'h0);
    check_eq("wrap2.valid", {31'b0, out_valid2}, 32'd1);
    check_eq("wrap2.pc", out_pc2, 32'hFFFF_FFF8);
    check_eq("wrap2.instr", out_instr2, 32'hBFFF_FFFE);
    tick();
    check_eq("wrap3.pc", out_pc2, 32'hFFFF_FFFC);
    check_eq("wrap3.instr", out_instr2, 32'hBFFF_FFFF);
    tick();
    check_eq("wrap4.pc", out_pc2, 32'h0);
    check_eq("wrap4.instr", out_instr2, 32'hA000_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
